// File: rtl/dm_pkg.sv
// Shared opcodes, FSM states and access-size decode for the data-memory responder.
package dm_pkg;
   localparam logic [5:0] OP_LB  = 6'd32;
   localparam logic [5:0] OP_LH  = 6'd33;
   localparam logic [5:0] OP_LW  = 6'd35;
   localparam logic [5:0] OP_LBU = 6'd36;
   localparam logic [5:0] OP_LHU = 6'd37;
   localparam logic [5:0] OP_SB  = 6'd40;
   localparam logic [5:0] OP_SH  = 6'd41;
   localparam logic [5:0] OP_SW  = 6'd43;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

   typedef struct packed {
      size_e size;
      logic  sext;
   } acc_t;

   // Unknown opcodes fall through to an unsigned word access.
   function automatic acc_t decode_op(input logic [5:0] op);
      acc_t a;
      a.size = SZ_W;
      a.sext = 1'b0;
      case (op)
         OP_LB:         begin a.size = SZ_B; a.sext = 1'b1; end
         OP_LBU, OP_SB: a.size = SZ_B;
         OP_LH:         begin a.size = SZ_H; a.sext = 1'b1; end
         OP_LHU, OP_SH: a.size = SZ_H;
         default:       ;
      endcase
      return a;
   endfunction

   function automatic logic misaligned(input acc_t a, input logic [1:0] lo);
      return ((a.size == SZ_H) && lo[0]) || ((a.size == SZ_W) && (lo != 2'b00));
   endfunction
endpackage

// File: rtl/dm_ram_bank.sv
// 32-bit little-endian data RAM with per-byte write enables and a registered read port.
module dm_ram_bank #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [3:0]        be,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [31:0]       rdata
);
   logic [31:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int k = 0; k < 4; k++) begin
            if (be[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
         end
      end
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/dm_responder.sv
// MEM-stage data-memory responder: stalls for LATENCY cycles, then stores or returns extended load data.
module dm_responder
   import dm_pkg::*;
#(
   parameter int LATENCY = 2,
   parameter int ADDR_W  = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead_en,
   input  logic        MemWrite_en,
   input  logic [5:0]  MemOp,
   input  logic [31:0] MemAddr,
   input  logic [31:0] MemWData,
   output logic        MemStall,
   output logic [31:0] MemRData,
   output logic        MemAddrErr
);
   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W+1:0] addr_q;
   logic [31:0]       wdata_q;
   acc_t              acc_q;
   logic              wr_q;
   logic [31:0]       rdata_q;

   logic        strobe, mis, accept, commit;
   acc_t        acc_in;
   logic [3:0]  ram_be;
   logic [31:0] ram_wdata, ram_rdata, ld_ext;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;

   assign strobe = MemRead_en | MemWrite_en;
   assign acc_in = decode_op(MemOp);
   assign mis    = misaligned(acc_in, MemAddr[1:0]);
   assign accept = (state_q == IDLE) && strobe && !mis;
   assign commit = (state_q == BUSY) && (cnt_q == 4'd0);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      MemStall   = 1'b0;
      MemAddrErr = 1'b0;
      case (state_q)
         IDLE: begin
            if (strobe) begin
               if (mis) begin
                  MemAddrErr = 1'b1;
               end else begin
                  MemStall = 1'b1;
                  cnt_d    = 4'(LATENCY - 1);
                  state_d  = BUSY;
               end
            end
         end
         BUSY: begin
            MemStall = 1'b1;
            if (cnt_q == 4'd0) state_d = DONE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Operands are frozen at acceptance; inputs are ignored for the rest of the access.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= MemAddr[ADDR_W+1:0];
         wdata_q <= MemWData;
         acc_q   <= acc_in;
         wr_q    <= MemWrite_en;
      end
   end

   always_comb begin
      ram_be    = 4'b1111;
      ram_wdata = wdata_q;
      case (acc_q.size)
         SZ_B: begin
            ram_be    = 4'b0001 << addr_q[1:0];
            ram_wdata = {4{wdata_q[7:0]}};
         end
         SZ_H: begin
            ram_be    = addr_q[1] ? 4'b1100 : 4'b0011;
            ram_wdata = {2{wdata_q[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_b   = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
      ld_h   = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      ld_ext = ram_rdata;
      case (acc_q.size)
         SZ_B:    ld_ext = {{24{acc_q.sext & ld_b[7]}}, ld_b};
         SZ_H:    ld_ext = {{16{acc_q.sext & ld_h[15]}}, ld_h};
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)                  rdata_q <= 32'd0;
      else if (commit && !wr_q) rdata_q <= ld_ext;
   end

   assign MemRData = rdata_q;

   // The read is launched at acceptance so the word is ready even with a single BUSY cycle.
   dm_ram_bank #(.ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .we    (commit && wr_q && !rst),
      .be    (ram_be),
      .waddr (addr_q[ADDR_W+1:2]),
      .wdata (ram_wdata),
      .re    (accept),
      .raddr (MemAddr[ADDR_W+1:2]),
      .rdata (ram_rdata)
   );
endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench: three responders (LATENCY 2, 1 with ADDR_W 4, and 15) driven one at a time.
module tb_dm_responder;
   import dm_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   logic [2:0]       rd_en, wr_en, stall, err;
   logic [5:0]       op;
   logic [31:0]      addr, wdata;
   logic [2:0][31:0] rdata;

   typedef struct {
      int          inst;
      int          len;
      logic [31:0] data;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad   = 0;
   int          lat[3] = '{2, 1, 15};
   logic [31:0] last_rd[3];
   int          run[3] = '{0, 0, 0};

   always #5 clk = ~clk;

   dm_responder #(.LATENCY(2), .ADDR_W(10)) u0 (
      .clk(clk), .rst(rst), .MemRead_en(rd_en[0]), .MemWrite_en(wr_en[0]), .MemOp(op),
      .MemAddr(addr), .MemWData(wdata), .MemStall(stall[0]), .MemRData(rdata[0]), .MemAddrErr(err[0]));
   dm_responder #(.LATENCY(1), .ADDR_W(4)) u1 (
      .clk(clk), .rst(rst), .MemRead_en(rd_en[1]), .MemWrite_en(wr_en[1]), .MemOp(op),
      .MemAddr(addr), .MemWData(wdata), .MemStall(stall[1]), .MemRData(rdata[1]), .MemAddrErr(err[1]));
   dm_responder #(.LATENCY(15), .ADDR_W(10)) u2 (
      .clk(clk), .rst(rst), .MemRead_en(rd_en[2]), .MemWrite_en(wr_en[2]), .MemOp(op),
      .MemAddr(addr), .MemWData(wdata), .MemStall(stall[2]), .MemRData(rdata[2]), .MemAddrErr(err[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Monitor: a falling MemStall marks the DONE cycle; pop and compare there.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            run[i] = 0;
         end else if (stall[i]) begin
            run[i]++;
         end else if (run[i] != 0) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 32'(i), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("done_inst", 32'(i), 32'(e.inst));
               chk("stall_len", 32'(run[i]), 32'(e.len));
               chk("rdata", rdata[i], e.data);
            end
            run[i] = 0;
         end
      end
   end

   task automatic access(input int inst, input logic [5:0] o, input logic [31:0] a,
                         input logic [31:0] d, input logic rd, input logic wr,
                         input logic [31:0] exp);
      int   n;
      exp_t e;
      if (rd && !wr) last_rd[inst] = exp;
      e.inst = inst;
      e.len  = lat[inst] + 1;
      e.data = last_rd[inst];
      q.push_back(e);
      op = o; addr = a; wdata = d;
      rd_en[inst] = rd; wr_en[inst] = wr;
      #1 chk("stall_at_accept", 32'(stall[inst]), 32'd1);
      for (n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (!stall[inst]) break;
      end
      if (n == 40) chk("done_timeout", 32'(n), 32'(lat[inst] + 1));
      @(posedge clk); #1;
      rd_en[inst] = 1'b0; wr_en[inst] = 1'b0;
   endtask

   task automatic misal(input int inst, input logic [5:0] o, input logic [31:0] a,
                        input logic rd, input logic wr);
      op = o; addr = a; wdata = 32'hFFFF_FFFF;
      rd_en[inst] = rd; wr_en[inst] = wr;
      #1;
      chk("addr_err", 32'(err[inst]), 32'd1);
      chk("mis_stall", 32'(stall[inst]), 32'd0);
      @(posedge clk); #1;
      rd_en[inst] = 1'b0; wr_en[inst] = 1'b0;
      #1 chk("addr_err_clr", 32'(err[inst]), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rd_en = '0; wr_en = '0; op = '0; addr = '0; wdata = '0;
      last_rd = '{32'd0, 32'd0, 32'd0};
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rst_stall", 32'(stall[i]), 32'd0);
         chk("rst_err", 32'(err[i]), 32'd0);
         chk("rst_rdata", rdata[i], 32'd0);
      end
      @(posedge clk); #1;

      // word round trip, byte lanes and sign
      access(0, OP_SW,  32'h10, 32'hDEAD_BEEF, 0, 1, 0);
      access(0, OP_LW,  32'h10, 32'h0,         1, 0, 32'hDEAD_BEEF);
      access(0, OP_SB,  32'h13, 32'hAAAA_AA80, 0, 1, 0);
      access(0, OP_LB,  32'h13, 32'h0,         1, 0, 32'hFFFF_FF80);
      access(0, OP_LBU, 32'h13, 32'h0,         1, 0, 32'h0000_0080);
      access(0, OP_LW,  32'h10, 32'h0,         1, 0, 32'h80AD_BEEF);

      // misalignment leaves memory alone
      access(0, OP_SW,  32'h20, 32'h0BAD_F00D, 0, 1, 0);
      misal(0, OP_LH, 32'h21, 1, 0);
      misal(0, OP_SW, 32'h22, 0, 1);
      access(0, OP_LW,  32'h20, 32'h0,         1, 0, 32'h0BAD_F00D);
      access(0, OP_SH,  32'h22, 32'hFFFF_1234, 0, 1, 0);
      access(0, OP_LHU, 32'h22, 32'h0,         1, 0, 32'h0000_1234);
      access(0, OP_LH,  32'h20, 32'h0,         1, 0, 32'hFFFF_F00D);
      access(0, OP_LW,  32'h20, 32'h0,         1, 0, 32'h1234_F00D);

      // reset during BUSY aborts the store and clears MemRData
      access(0, OP_SW,  32'h30, 32'h1111_1111, 0, 1, 0);
      op = OP_SW; addr = 32'h30; wdata = 32'h55; wr_en[0] = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1; wr_en[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      last_rd = '{32'd0, 32'd0, 32'd0};
      chk("abort_stall", 32'(stall[0]), 32'd0);
      chk("abort_rdata", rdata[0], 32'd0);
      access(0, OP_LW,  32'h30, 32'h0,         1, 0, 32'h1111_1111);

      // both strobes: store only, MemRData held
      access(0, OP_SW,  32'h34, 32'hCAFE_0001, 1, 1, 0);
      access(0, OP_LW,  32'h34, 32'h0,         1, 0, 32'hCAFE_0001);
      access(0, 6'd0,   32'h34, 32'h0,         1, 0, 32'hCAFE_0001);

      // LATENCY=1, ADDR_W=4: wrap-around and back-to-back
      access(1, OP_SW,  32'h40, 32'hA5A5_0F0F, 0, 1, 0);
      access(1, OP_LW,  32'h00, 32'h0,         1, 0, 32'hA5A5_0F0F);
      access(1, OP_SB,  32'h01, 32'h0000_007F, 0, 1, 0);
      access(1, OP_LH,  32'h00, 32'h0,         1, 0, 32'h0000_7F0F);
      access(1, OP_LB,  32'h41, 32'h0,         1, 0, 32'h0000_007F);

      // LATENCY=15
      access(2, OP_SW,  32'h04, 32'h0000_0001, 0, 1, 0);
      access(2, OP_LW,  32'h04, 32'h0,         1, 0, 32'h0000_0001);

      repeat (4) @(posedge clk);
      #1 chk("sb_empty", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
